dm_req_rsp: RTL and testbench
=============================

// Module: dm_req_rsp
// PURPOSE
//  Next-generation data memory for the SCPU load/store unit. Word-organised, little-endian, byte-addressed.
//  Requests use a valid/ready handshake; each accepted request returns exactly one registered response.
//  Memory depth is parametrised. Sub-word stores use byte enables.
//  Misaligned or illegal accesses are reported with an error flag and counted in a saturating counter.
// PARAMETERS
//  ADDR_WIDTH     12  byte-address width; depth = 2**(ADDR_WIDTH-2) 32-bit words
//  MISALIGN_TRAP  1   1: misaligned access -> error response, no write; 0: low addr bits forced to alignment
// PORTS
//  clk        in   1           clock; all state updates on posedge
//  rstn       in   1           asynchronous, active-low reset
//  req_valid  in   1           request present
//  req_ready  out  1           request can be accepted this cycle
//  req_addr   in   ADDR_WIDTH  byte address
//  req_wr     in   2           store mode: 00 NOP, 01 SW, 10 SH, 11 SB
//  req_rd     in   3           load mode: 000 NOP, 001 LW, 010 LH, 011 LHU, 100 LB, 101 LBU, others illegal
//  req_wdata  in   32          store data; SH uses [15:0], SB uses [7:0]
//  rsp_valid  out  1           response present
//  rsp_ready  in   1           consumer takes response
//  rsp_rdata  out  32          load result; 0 for stores, NOPs and errors
//  rsp_err    out  1           response is an error (misaligned or illegal)
//  err_cnt    out  8           number of error responses issued, saturates at 255
// BEHAVIOUR
//  Reset (rstn low, async): state IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, err_cnt=0; req_ready=1 after release.
//   Memory contents are not reset. A pending response is dropped.
//   A request presented at an edge where rstn is low is not accepted and not written.
//  FSM: IDLE, RESP.
//   req_ready = (state==IDLE) | (state==RESP & rsp_ready).
//   Accept = req_valid & req_ready at posedge N.
//   On accept: state->RESP, rsp_* loaded at edge N, rsp_valid=1 from N until the rsp handshake edge.
//   RESP & rsp_ready & !accept -> IDLE, rsp_valid=0.
//   RESP & rsp_ready & accept -> stays RESP with the new response (back-to-back, 1 request/cycle).
//   RESP & !rsp_ready: rsp_* held stable, req_ready=0.
//  Latency: response 1 cycle after acceptance. A store commits at the accept edge.
//   A load accepted on the next cycle returns the new data (read-after-write at same address is coherent).
//  Lanes (little-endian, word = addr[ADDR_WIDTH-1:2]):
//   SW writes all 4 bytes.
//   SH writes bytes {addr[1],0} and {addr[1],1} with wdata[15:0].
//   SB writes byte addr[1:0] with wdata[7:0].
//   LW returns the word.
//   LH/LHU: halfword at addr[1]; LH sign-extends bit 15, LHU zero-extends.
//   LB/LBU: byte at addr[1:0]; LB sign-extends bit 7, LBU zero-extends.
//  Alignment: W requires addr[1:0]=00; H requires addr[0]=0; B is always aligned.
//   MISALIGN_TRAP=1: misaligned -> rsp_err=1, rdata=0, no write.
//   MISALIGN_TRAP=0: offending bits treated as 0, normal access, rsp_err=0.
//  Illegal (rsp_err=1, rdata=0, no write):
//   req_wr!=00 and req_rd!=000 both set;
//   req_rd in 110, 111.
//  Both NOP: accepted, response rdata=0, err=0.
//  err_cnt increments on the edge an error response is loaded; it holds at 255.
// TESTING
//  T1: SW 0xDEADBEEF @0x010, then LW @0x010 -> rdata 0xDEADBEEF, err 0, rsp_valid 1 cycle after accept.
//  T2: SB 0x80 @0x013, then LB @0x013 -> 0xFFFFFF80; LBU -> 0x00000080.
//   SH 0x8001 @0x012, then LH -> 0xFFFF8001; LHU -> 0x00008001; LW @0x010 -> 0x8001BEEF.
//  T3: MISALIGN_TRAP=1: SW @0x011 -> err 1, err_cnt 1, LW @0x010 unchanged.
//   LH @0x013 -> err 1, err_cnt 2.
//   MISALIGN_TRAP=0 build: LW @0x011 returns word @0x010, err 0.
//  T4: back-to-back SW then LW with rsp_ready=1 -> req_ready stays 1, one response per cycle, second returns stored data.
//   Hold rsp_ready=0 for 3 cycles -> rsp_* stable, req_ready=0, no request lost.
//  T5: req_wr=01 with req_rd=001 -> err 1, no write.
//   req_rd=111 -> err 1. Force 300 errors -> err_cnt=255.
//  T6: assert rstn low mid-RESP with a store presented -> rsp_valid 0 immediately, err_cnt 0, store not committed.

Source files
------------

// File: rtl/dm_req_rsp.sv
// ----------------------------------------------------------------------------
// dm_req_rsp
// Word-organised, little-endian, byte-addressed data memory for the SCPU
// load/store unit. One request per cycle over a valid/ready handshake; every
// accepted request produces exactly one registered response one cycle later.
// Stores commit at the accept edge, so a load accepted on the next cycle sees
// the new data. Misaligned or illegal requests return an error response and
// bump a saturating error counter.
//
// Parameters
//   ADDR_WIDTH     byte-address width; depth = 2**(ADDR_WIDTH-2) words
//   MISALIGN_TRAP  1: misaligned access is an error (no write)
//                  0: offending low address bits are forced to alignment
//
// Ports
//   i_clk         clock, all state on posedge
//   i_rstn        asynchronous active-low reset
//   i_req_valid   request present
//   o_req_ready   request can be accepted this cycle
//   i_req_addr    byte address
//   i_req_wr      store mode: 00 NOP, 01 SW, 10 SH, 11 SB
//   i_req_rd      load mode: 000 NOP, 001 LW, 010 LH, 011 LHU, 100 LB,
//                 101 LBU, 110/111 illegal
//   i_req_wdata   store data (SH uses [15:0], SB uses [7:0])
//   o_rsp_valid   response present
//   i_rsp_ready   consumer takes the response
//   o_rsp_rdata   load result; 0 for stores, NOPs and errors
//   o_rsp_err     response is an error
//   o_err_cnt     error responses issued, saturates at 255
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no response outstanding, ready for a request
// RESP  | response held on rsp_*; new request accepted only with rsp_ready
// ----------------------------------------------------------------------------
module dm_req_rsp #(
    parameter int ADDR_WIDTH    = 12,
    parameter int MISALIGN_TRAP = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [1:0]            i_req_wr,
    input  logic [2:0]            i_req_rd,
    input  logic [31:0]           i_req_wdata,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [31:0]           o_rsp_rdata,
    output logic                  o_rsp_err,
    output logic [7:0]            o_err_cnt
);

    localparam int WORD_AW = ADDR_WIDTH - 2;
    localparam int DEPTH   = 2 ** WORD_AW;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [31:0]        r_mem [DEPTH];
    logic               r_rsp_valid;
    logic [31:0]        r_rsp_rdata;
    logic               r_rsp_err;
    logic [7:0]         r_err_cnt;

    logic               w_req_ready;
    logic               w_accept;
    logic               w_is_store;
    logic               w_is_load;
    logic               w_sz_word;
    logic               w_sz_half;
    logic               w_illegal;
    logic               w_misalign;
    logic               w_err;
    logic [1:0]         w_off;
    logic [WORD_AW-1:0] w_word;
    logic               w_we;
    logic [3:0]         w_be;
    logic [31:0]        w_wlane;
    logic [31:0]        w_rword;
    logic [15:0]        w_rhalf;
    logic [7:0]         w_rbyte;
    logic [31:0]        w_rdata;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_req_ready = 1'b1;
                if (w_accept) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                w_req_ready = i_rsp_ready;
                if (i_rsp_ready && !w_accept) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Gating with i_rstn keeps a request presented during reset from
    // reaching the (non-reset) memory array.
    assign w_accept    = i_req_valid & w_req_ready & i_rstn;
    assign o_req_ready = w_req_ready;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    always_comb begin
        w_is_store = (i_req_wr != 2'b00);
        w_is_load  = (i_req_rd != 3'b000);
        w_illegal  = (w_is_store && w_is_load) || (i_req_rd[2:1] == 2'b11);

        w_sz_word = 1'b0;
        w_sz_half = 1'b0;
        if (w_is_store) begin
            w_sz_word = (i_req_wr == 2'b01);
            w_sz_half = (i_req_wr == 2'b10);
        end else begin
            w_sz_word = (i_req_rd == 3'b001);
            w_sz_half = (i_req_rd == 3'b010) || (i_req_rd == 3'b011);
        end

        if (w_sz_word) begin
            w_misalign = (i_req_addr[1:0] != 2'b00);
        end else if (w_sz_half) begin
            w_misalign = i_req_addr[0];
        end else begin
            w_misalign = 1'b0;
        end

        if (MISALIGN_TRAP != 0) begin
            w_err = w_illegal | w_misalign;
            w_off = i_req_addr[1:0];
        end else begin
            // Alignment forced: word drops both bits, half drops bit 0.
            w_err = w_illegal;
            if (w_sz_word) begin
                w_off = 2'b00;
            end else if (w_sz_half) begin
                w_off = {i_req_addr[1], 1'b0};
            end else begin
                w_off = i_req_addr[1:0];
            end
        end

        w_word = i_req_addr[ADDR_WIDTH-1:2];
    end

    // ------------------------------------------------------------------
    // Store path: byte enables and replicated lane data
    // ------------------------------------------------------------------
    always_comb begin
        w_be    = 4'b0000;
        w_wlane = i_req_wdata;
        case (i_req_wr)
            2'b01: begin
                w_be    = 4'b1111;
                w_wlane = i_req_wdata;
            end
            2'b10: begin
                w_be    = w_off[1] ? 4'b1100 : 4'b0011;
                w_wlane = {2{i_req_wdata[15:0]}};
            end
            2'b11: begin
                w_be    = 4'b0001 << w_off;
                w_wlane = {4{i_req_wdata[7:0]}};
            end
            default: begin
                w_be    = 4'b0000;
                w_wlane = i_req_wdata;
            end
        endcase
    end

    assign w_we = w_accept & w_is_store & ~w_err;

    always_ff @(posedge i_clk) begin
        for (int b = 0; b < 4; b++) begin
            if (w_we && w_be[b]) begin
                r_mem[w_word][8*b +: 8] <= w_wlane[8*b +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Load path: lane select and extension
    // ------------------------------------------------------------------
    always_comb begin
        w_rword = r_mem[w_word];
        w_rhalf = w_off[1] ? w_rword[31:16] : w_rword[15:0];
        case (w_off)
            2'b00:   w_rbyte = w_rword[7:0];
            2'b01:   w_rbyte = w_rword[15:8];
            2'b10:   w_rbyte = w_rword[23:16];
            default: w_rbyte = w_rword[31:24];
        endcase

        w_rdata = 32'h0;
        if (!w_err && !w_is_store) begin
            case (i_req_rd)
                3'b001:  w_rdata = w_rword;
                3'b010:  w_rdata = {{16{w_rhalf[15]}}, w_rhalf};
                3'b011:  w_rdata = {16'h0, w_rhalf};
                3'b100:  w_rdata = {{24{w_rbyte[7]}}, w_rbyte};
                3'b101:  w_rdata = {24'h0, w_rbyte};
                default: w_rdata = 32'h0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Response registers and error counter
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= w_rdata;
            r_rsp_err   <= w_err;
        end else if (r_state == S_RESP && i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_err_cnt <= 8'h00;
        end else if (w_accept && w_err && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_err   = r_rsp_err;
    assign o_err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_dm_req_rsp.sv
// ----------------------------------------------------------------------------
// tb_dm_req_rsp
// Directed bench for dm_req_rsp. Two instances share the request stimulus:
// dut (misaligned accesses trap) and dut0 (misaligned accesses are aligned).
// Inputs change on the falling edge, outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_dm_req_rsp;

    logic        clk;
    logic        rstn;
    logic        req_valid;
    logic [11:0] req_addr;
    logic [1:0]  req_wr;
    logic [2:0]  req_rd;
    logic [31:0] req_wdata;
    logic        rsp_ready;

    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [7:0]  err_cnt;

    logic        req_ready0;
    logic        rsp_valid0;
    logic [31:0] rsp_rdata0;
    logic        rsp_err0;
    logic [7:0]  err_cnt0;

    int n_vec;
    int n_miscmp;

    dm_req_rsp #(.ADDR_WIDTH(12), .MISALIGN_TRAP(1)) dut (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_addr  (req_addr),
        .i_req_wr    (req_wr),
        .i_req_rd    (req_rd),
        .i_req_wdata (req_wdata),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_rdata (rsp_rdata),
        .o_rsp_err   (rsp_err),
        .o_err_cnt   (err_cnt)
    );

    dm_req_rsp #(.ADDR_WIDTH(12), .MISALIGN_TRAP(0)) dut0 (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready0),
        .i_req_addr  (req_addr),
        .i_req_wr    (req_wr),
        .i_req_rd    (req_rd),
        .i_req_wdata (req_wdata),
        .o_rsp_valid (rsp_valid0),
        .i_rsp_ready (rsp_ready),
        .o_rsp_rdata (rsp_rdata0),
        .o_rsp_err   (rsp_err0),
        .o_err_cnt   (err_cnt0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miscmp++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Presents one request (assumes req_ready is high), then returns at the
    // following falling edge with the response visible.
    task automatic send(input logic [1:0] wr, input logic [2:0] rd,
                        input logic [11:0] addr, input logic [31:0] wd);
        req_valid = 1'b1;
        req_wr    = wr;
        req_rd    = rd;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_wr    = 2'b00;
        req_rd    = 3'b000;
    endtask

    task automatic chk_rsp(input string tag, input logic [31:0] rd, input logic er);
        chk({tag, "_valid"}, {31'h0, rsp_valid}, 32'h1);
        chk({tag, "_rdata"}, rsp_rdata, rd);
        chk({tag, "_err"},   {31'h0, rsp_err}, {31'h0, er});
    endtask

    initial begin
        n_vec     = 0;
        n_miscmp  = 0;
        rstn      = 1'b0;
        req_valid = 1'b0;
        req_addr  = 12'h0;
        req_wr    = 2'b00;
        req_rd    = 3'b000;
        req_wdata = 32'h0;
        rsp_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_err",   {31'h0, rsp_err}, 32'h0);
        chk("rst_cnt",   {24'h0, err_cnt}, 32'h0);
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_ready", {31'h0, req_ready}, 32'h1);

        // T1: word store then load
        send(2'b01, 3'b000, 12'h010, 32'hDEADBEEF);
        chk_rsp("t1_sw", 32'h0, 1'b0);
        send(2'b00, 3'b001, 12'h010, 32'h0);
        chk_rsp("t1_lw", 32'hDEADBEEF, 1'b0);

        // T2: sub-word stores and sign/zero extension
        send(2'b11, 3'b000, 12'h013, 32'h00000080);
        send(2'b00, 3'b100, 12'h013, 32'h0);
        chk_rsp("t2_lb", 32'hFFFFFF80, 1'b0);
        send(2'b00, 3'b101, 12'h013, 32'h0);
        chk_rsp("t2_lbu", 32'h00000080, 1'b0);
        send(2'b10, 3'b000, 12'h012, 32'h00008001);
        send(2'b00, 3'b010, 12'h012, 32'h0);
        chk_rsp("t2_lh", 32'hFFFF8001, 1'b0);
        send(2'b00, 3'b011, 12'h012, 32'h0);
        chk_rsp("t2_lhu", 32'h00008001, 1'b0);
        send(2'b00, 3'b001, 12'h010, 32'h0);
        chk_rsp("t2_lw", 32'h8001BEEF, 1'b0);
        send(2'b00, 3'b100, 12'h010, 32'h0);
        chk_rsp("t2_lb0", 32'hFFFFFFEF, 1'b0);

        // T3: misalignment (trap instance vs aligning instance)
        send(2'b01, 3'b000, 12'h011, 32'h12345678);
        chk_rsp("t3_sw_mis", 32'h0, 1'b1);
        chk("t3_cnt1", {24'h0, err_cnt}, 32'd1);
        chk("t3_sw_mis_err0", {31'h0, rsp_err0}, 32'h0);
        send(2'b00, 3'b001, 12'h010, 32'h0);
        chk_rsp("t3_lw_keep", 32'h8001BEEF, 1'b0);
        chk("t3_lw_dut0", rsp_rdata0, 32'h12345678);
        send(2'b00, 3'b010, 12'h013, 32'h0);
        chk_rsp("t3_lh_mis", 32'h0, 1'b1);
        chk("t3_cnt2", {24'h0, err_cnt}, 32'd2);
        chk("t3_lh_dut0", rsp_rdata0, 32'h00001234);
        send(2'b00, 3'b001, 12'h011, 32'h0);
        chk("t3_cnt3", {24'h0, err_cnt}, 32'd3);
        chk("t3_lw_mis_dut0", rsp_rdata0, 32'h12345678);
        chk("t3_lw_mis_err0", {31'h0, rsp_err0}, 32'h0);

        // T4: back-to-back requests, one response per cycle
        req_valid = 1'b1; req_wr = 2'b01; req_rd = 3'b000;
        req_addr  = 12'h020; req_wdata = 32'hCAFEF00D;
        chk("t4_ready_a", {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        chk_rsp("t4_sw", 32'h0, 1'b0);
        chk("t4_ready_b", {31'h0, req_ready}, 32'h1);
        req_wr = 2'b00; req_rd = 3'b001;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_rd = 3'b000;
        chk_rsp("t4_lw", 32'hCAFEF00D, 1'b0);

        // T4: back-pressure for 3 cycles with a request waiting
        @(negedge clk);
        rsp_ready = 1'b0;
        send(2'b00, 3'b001, 12'h010, 32'h0);
        req_valid = 1'b1; req_rd = 3'b100; req_addr = 12'h010;
        for (int i = 0; i < 3; i++) begin
            chk_rsp("t4_hold", 32'h8001BEEF, 1'b0);
            chk("t4_hold_ready", {31'h0, req_ready}, 32'h0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_rd = 3'b000;
        chk_rsp("t4_waited_lb", 32'hFFFFFFEF, 1'b0);
        @(negedge clk);
        chk("t4_drained", {31'h0, rsp_valid}, 32'h0);

        // T5: illegal encodings and counter saturation
        send(2'b01, 3'b000, 12'h030, 32'h11111111);
        send(2'b01, 3'b001, 12'h030, 32'h55555555);
        chk_rsp("t5_both", 32'h0, 1'b1);
        chk("t5_cnt4", {24'h0, err_cnt}, 32'd4);
        send(2'b00, 3'b001, 12'h030, 32'h0);
        chk_rsp("t5_nowrite", 32'h11111111, 1'b0);
        send(2'b00, 3'b111, 12'h030, 32'h0);
        chk_rsp("t5_rd111", 32'h0, 1'b1);
        chk("t5_cnt5", {24'h0, err_cnt}, 32'd5);
        send(2'b00, 3'b000, 12'h030, 32'h0);
        chk_rsp("t5_nop", 32'h0, 1'b0);
        chk("t5_cnt_nop", {24'h0, err_cnt}, 32'd5);
        req_valid = 1'b1; req_rd = 3'b110; req_addr = 12'h030;
        repeat (249) @(posedge clk);
        @(negedge clk);
        chk("t5_cnt254", {24'h0, err_cnt}, 32'd254);
        repeat (46) @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_rd = 3'b000;
        chk("t5_cnt_sat", {24'h0, err_cnt}, 32'd255);
        chk("t5_last_err", {31'h0, rsp_err}, 32'h1);

        // T6: reset while a response is held and a store is presented
        @(negedge clk);
        rsp_ready = 1'b0;
        send(2'b00, 3'b001, 12'h030, 32'h0);
        req_valid = 1'b1; req_wr = 2'b01; req_addr = 12'h030; req_wdata = 32'h99999999;
        chk("t6_pre_valid", {31'h0, rsp_valid}, 32'h1);
        #2;
        rstn = 1'b0;
        #1;
        chk("t6_rst_valid", {31'h0, rsp_valid}, 32'h0);
        chk("t6_rst_cnt",   {24'h0, err_cnt}, 32'h0);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_wr = 2'b00;
        rstn = 1'b1;
        @(negedge clk);
        send(2'b00, 3'b001, 12'h030, 32'h0);
        chk_rsp("t6_no_commit", 32'h11111111, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
